pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush sequencer for the 16-bit five-stage pipeline. Each cycle it computes the write enables for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus bubble-insert (flush) strobes for IF/ID and ID/EX. It resolves load-use hazards, taken-branch squashes, memory wait states and halt drain. A small state machine retires an HLT cleanly before freezing the core.

## Interface
Parameters:
- DRAIN_CYCLES, 3: cycles needed for HLT to travel from ID/EX to MEM/WB after it leaves ID.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- ifid_rs  in  4  source register 1 of the instruction in ID.
- ifid_rt  in  4  source register 2 of the instruction in ID.
- ifid_uses_rt  in  1  the instruction in ID reads rt.
- idex_rd  in  4  destination register of the instruction in EX.
- idex_memread  in  1  the instruction in EX is a load.
- id_branch_taken  in  1  the branch or branch-register instruction in ID resolved taken.
- id_hlt  in  1  the instruction in ID is HLT.
- if_miss  in  1  instruction memory not ready this cycle.
- mem_miss  in  1  data memory not ready this cycle.
- pc_we  out  1  PC update enable.
- ifid_we  out  1  IF/ID write enable.
- ifid_flush  out  1  load a NOP into IF/ID.
- idex_we  out  1  ID/EX write enable.
- idex_flush  out  1  zero all control signals entering ID/EX (bubble).
- exmem_we  out  1  EX/MEM write enable.
- memwb_we  out  1  MEM/WB write enable.
- halted  out  1  core frozen after HLT retired; registered.

## Operation
- States: RUN, DRAIN, HALTED. Reset enters RUN with the drain counter cleared to 0.
- Load-use hazard (luh): idex_memread & (idex_rd != 0) & ((idex_rd == ifid_rs) | (ifid_uses_rt & idex_rd == ifid_rt)). Register 0 never creates a hazard.
- Output priority in RUN, highest first:
  1. mem_miss: all five write enables are 0 and both flushes are 0. The whole pipeline freezes, including IF.
  2. luh: pc_we=0, ifid_we=0, idex_flush=1. Other enables are 1. Branch and HLT in ID are ignored this cycle and re-evaluated next cycle.
  3. id_hlt: ifid_flush=1, pc_we=0, everything else advances. Next state is DRAIN with the counter at 0.
  4. id_branch_taken: ifid_flush=1. All enables are 1.
  5. if_miss: pc_we=0, ifid_flush=1 (fetch bubble). Downstream stages advance.
  6. Otherwise all enables are 1 and both flushes are 0.
- Simultaneous events: id_branch_taken and if_miss in the same cycle gives pc_we=1 and ifid_flush=1. The redirect wins.
- DRAIN:
  - pc_we=0 and ifid_flush=1 every cycle. if_miss and ID inputs are ignored.
  - mem_miss freezes the stages and pauses the counter.
  - Otherwise the counter increments. On the cycle it reaches DRAIN_CYCLES-1 with no mem_miss, the next state is HALTED.
- HALTED: all enables are 0, both flushes are 0, halted=1. Only rst leaves this state.
- While rst=1: all enables are 1, both flushes are 0, halted=0. The pipeline registers clear in parallel.

## Timing
- Enables and flushes are combinational from the current state and inputs, with zero-cycle latency. They are sampled by the pipeline registers at the same clk edge.
- A load-use stall lasts exactly 1 cycle when no mem_miss occurs. luh deasserts once the load advances to EX/MEM.
- HLT decoded at edge N, with no misses, gives halted=1 after edge N+1+DRAIN_CYCLES.
- halted, the state and the counter update on clk only.
- rst asserted during DRAIN returns to RUN on the next edge.

## Configuration
- PIPE_HAZARD_PERF_EN defined: adds two outputs.
  - stall_cnt[15:0] counts cycles with luh, mem_miss or if_miss active in RUN.
  - flush_cnt[15:0] counts cycles with ifid_flush or idex_flush asserted in RUN.
  - Both counters wrap at 0xFFFF to 0, reset to 0 and hold in HALTED.
- Not defined: the counters and ports are absent, and behaviour is otherwise identical.

## Structure
- Shared package pipe_pkg: the state enum (RUN, DRAIN, HALTED), DRAIN_CYCLES default, and the register-index width constant (4).
- One sub-module, load_use_detect: purely combinational luh compare, reusable by the forwarding unit.

## Test plan
- Load r3 in EX, ID reads rs=3 -> one cycle with pc_we=0, ifid_we=0, idex_flush=1, then normal flow.
- Load r0 in EX, ID reads rs=0 -> no stall, all enables 1.
- Load r5 in EX with mem_miss=1 for 2 cycles while ID reads rt=5 with ifid_uses_rt=1 -> 2 fully frozen cycles, then a 1-cycle load-use bubble.
- id_branch_taken=1 with if_miss=1 -> pc_we=1 and ifid_flush=1 in the same cycle.
- id_hlt=1 at cycle 10 with no misses -> DRAIN for 3 cycles, then halted=1 after edge 14. A mem_miss pulse during DRAIN extends this by 1 cycle.
- rst during DRAIN -> RUN and halted=0 next edge. With PIPE_HAZARD_PERF_EN defined, stall_cnt=0 and flush_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the pipeline hazard/stall control logic.
//   REG_IDX_W        - width of a register-file index (16 registers)
//   DRAIN_CYCLES_DEF - default cycles for HLT to travel ID/EX -> MEM/WB
//   hz_state_e       - sequencer states: RUN, DRAIN, HALTED
package pipe_pkg;

  localparam int unsigned REG_IDX_W        = 4;
  localparam int unsigned DRAIN_CYCLES_DEF = 3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs from the pipeline and the stall/flush
// controls returned to it.
//   slave  modport: the hazard controller (reads ID/EX/miss info, drives
//                   enables, flushes and halted)
//   master modport: the pipeline datapath side
interface pipe_hazard_ctrl_if;
  import pipe_pkg::*;

  logic [REG_IDX_W-1:0] ifid_rs;
  logic [REG_IDX_W-1:0] ifid_rt;
  logic                 ifid_uses_rt;
  logic [REG_IDX_W-1:0] idex_rd;
  logic                 idex_memread;
  logic                 id_branch_taken;
  logic                 id_hlt;
  logic                 if_miss;
  logic                 mem_miss;

  logic                 pc_we;
  logic                 ifid_we;
  logic                 ifid_flush;
  logic                 idex_we;
  logic                 idex_flush;
  logic                 exmem_we;
  logic                 memwb_we;
  logic                 halted;

  modport slave (
    input  ifid_rs, ifid_rt, ifid_uses_rt, idex_rd, idex_memread,
           id_branch_taken, id_hlt, if_miss, mem_miss,
    output pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
           exmem_we, memwb_we, halted
  );

  modport master (
    output ifid_rs, ifid_rt, ifid_uses_rt, idex_rd, idex_memread,
           id_branch_taken, id_hlt, if_miss, mem_miss,
    input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
           exmem_we, memwb_we, halted
  );

endinterface

// File: rtl/load_use_detect.sv
// load_use_detect: purely combinational load-use hazard compare.
//   i_ifid_rs, i_ifid_rt - source registers of the instruction in ID
//   i_ifid_uses_rt       - ID instruction actually reads rt
//   i_idex_rd            - destination of the instruction in EX
//   i_idex_memread       - EX instruction is a load
//   o_luh                - stall required (register 0 never hazards)
module load_use_detect
  import pipe_pkg::*;
(
  input  logic [REG_IDX_W-1:0] i_ifid_rs,
  input  logic [REG_IDX_W-1:0] i_ifid_rt,
  input  logic                 i_ifid_uses_rt,
  input  logic [REG_IDX_W-1:0] i_idex_rd,
  input  logic                 i_idex_memread,
  output logic                 o_luh
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = (i_idex_rd == i_ifid_rs);
  assign w_rt_hit = i_ifid_uses_rt && (i_idex_rd == i_ifid_rt);
  assign o_luh    = i_idex_memread && (i_idex_rd != '0) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush sequencer for the five-stage pipeline.
//   clk, rst   - clock, synchronous active-high reset
//   hz (slave) - ID/EX hazard info and miss flags in; PC / IF/ID / ID/EX /
//                EX/MEM / MEM/WB write enables, IF/ID and ID/EX flushes and
//                registered halted out
// Enables/flushes are combinational from state and inputs. An HLT in ID moves
// the sequencer to DRAIN for DRAIN_CYCLES unfrozen cycles, then HALTED.
// Optional: define PIPE_HAZARD_PERF_EN to add stall_cnt / flush_cnt outputs.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

  hz_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_halted;

  logic w_luh;
  logic w_pc_we;
  logic w_ifid_we;
  logic w_ifid_flush;
  logic w_idex_we;
  logic w_idex_flush;
  logic w_exmem_we;
  logic w_memwb_we;

  load_use_detect u_luh (
    .i_ifid_rs      (hz.ifid_rs),
    .i_ifid_rt      (hz.ifid_rt),
    .i_ifid_uses_rt (hz.ifid_uses_rt),
    .i_idex_rd      (hz.idex_rd),
    .i_idex_memread (hz.idex_memread),
    .o_luh          (w_luh)
  );

  always_comb begin
    w_pc_we      = 1'b1;
    w_ifid_we    = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_we    = 1'b1;
    w_idex_flush = 1'b0;
    w_exmem_we   = 1'b1;
    w_memwb_we   = 1'b1;
    if (!rst) begin
      unique case (r_state)
        RUN: begin
          if (hz.mem_miss) begin
            w_pc_we    = 1'b0;
            w_ifid_we  = 1'b0;
            w_idex_we  = 1'b0;
            w_exmem_we = 1'b0;
            w_memwb_we = 1'b0;
          end else if (w_luh) begin
            w_pc_we      = 1'b0;
            w_ifid_we    = 1'b0;
            w_idex_flush = 1'b1;
          end else if (hz.id_hlt) begin
            w_pc_we      = 1'b0;
            w_ifid_flush = 1'b1;
          end else if (hz.id_branch_taken) begin
            // Redirect keeps pc_we even when fetch misses in the same cycle.
            w_ifid_flush = 1'b1;
          end else if (hz.if_miss) begin
            w_pc_we      = 1'b0;
            w_ifid_flush = 1'b1;
          end
        end
        DRAIN: begin
          w_pc_we      = 1'b0;
          w_ifid_flush = 1'b1;
          if (hz.mem_miss) begin
            w_ifid_we  = 1'b0;
            w_idex_we  = 1'b0;
            w_exmem_we = 1'b0;
            w_memwb_we = 1'b0;
          end
        end
        default: begin
          w_pc_we    = 1'b0;
          w_ifid_we  = 1'b0;
          w_idex_we  = 1'b0;
          w_exmem_we = 1'b0;
          w_memwb_we = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RUN;
      r_cnt    <= '0;
      r_halted <= 1'b0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (!hz.mem_miss && !w_luh && hz.id_hlt) begin
            r_state <= DRAIN;
            r_cnt   <= '0;
          end
        end
        DRAIN: begin
          if (!hz.mem_miss) begin
            if (r_cnt == CNT_LAST) begin
              r_state  <= HALTED;
              r_halted <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        HALTED: begin
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (r_state == RUN) begin
      if (w_luh || hz.mem_miss || hz.if_miss) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_ifid_flush || w_idex_flush)       r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

  assign hz.pc_we      = w_pc_we;
  assign hz.ifid_we    = w_ifid_we;
  assign hz.ifid_flush = w_ifid_flush;
  assign hz.idex_we    = w_idex_we;
  assign hz.idex_flush = w_idex_flush;
  assign hz.exmem_we   = w_exmem_we;
  assign hz.memwb_we   = w_memwb_we;
  assign hz.halted     = r_halted;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int DC = 3;

  // Output vector order: {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we}
  localparam logic [6:0] V_NORM  = 7'b1101011;
  localparam logic [6:0] V_FRZ   = 7'b0000000;
  localparam logic [6:0] V_LUH   = 7'b0001111;
  localparam logic [6:0] V_BUB   = 7'b0111011;
  localparam logic [6:0] V_BR    = 7'b1111011;
  localparam logic [6:0] V_DRMM  = 7'b0010000;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pipe_hazard_ctrl_if bus ();

`ifdef PIPE_HAZARD_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  pipe_hazard_ctrl #(.DRAIN_CYCLES(DC)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (bus)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_left;    // remaining unfrozen drain cycles, 0 = not draining
  bit          m_halted;
  logic [15:0] m_stall;
  logic [15:0] m_flush;

  function automatic bit m_luh();
    return bus.idex_memread && (bus.idex_rd != 4'd0) &&
           ((bus.idex_rd == bus.ifid_rs) || (bus.ifid_uses_rt && (bus.idex_rd == bus.ifid_rt)));
  endfunction

  function automatic logic [6:0] m_exp();
    if (rst)                  return V_NORM;
    if (m_halted)             return V_FRZ;
    if (m_left > 0)           return bus.mem_miss ? V_DRMM : V_BUB;
    if (bus.mem_miss)         return V_FRZ;
    if (m_luh())              return V_LUH;
    if (bus.id_hlt)           return V_BUB;
    if (bus.id_branch_taken)  return V_BR;
    if (bus.if_miss)          return V_BUB;
    return V_NORM;
  endfunction

  function automatic logic [6:0] dut_vec();
    return {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_we,
            bus.idex_flush, bus.exmem_we, bus.memwb_we};
  endfunction

  always @(posedge clk) begin
    logic [6:0] v;
    if (rst) begin
      m_left = 0; m_halted = 0; m_stall = '0; m_flush = '0;
    end else if (m_halted) begin
      m_left = 0;
    end else if (m_left > 0) begin
      if (!bus.mem_miss) begin
        m_left = m_left - 1;
        if (m_left == 0) m_halted = 1;
      end
    end else begin
      v = m_exp();
      if (bus.mem_miss || m_luh() || bus.if_miss) m_stall = m_stall + 16'd1;
      if (v[4] || v[2])                           m_flush = m_flush + 16'd1;
      if (!bus.mem_miss && !m_luh() && bus.id_hlt) m_left = DC;
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    checks = checks + 1;
    if (dut_vec() !== m_exp() || bus.halted !== m_halted) begin
      failures = failures + 1;
      $display("FAIL model_cmp t=%0t got vec=%b halted=%b want vec=%b halted=%b",
               $time, dut_vec(), bus.halted, m_exp(), m_halted);
    end
`ifdef PIPE_HAZARD_PERF_EN
    checks = checks + 1;
    if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
      failures = failures + 1;
      $display("FAIL perf_cmp t=%0t got stall=%0d flush=%0d want stall=%0d flush=%0d",
               $time, stall_cnt, flush_cnt, m_stall, m_flush);
    end
`endif
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] rs, input logic [3:0] rt, input logic urt,
                        input logic [3:0] rd, input logic mr, input logic br,
                        input logic hlt, input logic ifm, input logic mm);
    bus.ifid_rs = rs; bus.ifid_rt = rt; bus.ifid_uses_rt = urt;
    bus.idex_rd = rd; bus.idex_memread = mr; bus.id_branch_taken = br;
    bus.id_hlt = hlt; bus.if_miss = ifm; bus.mem_miss = mm;
  endtask

  task automatic lit_v(input string nm, input logic [6:0] want);
    #3;
    checks = checks + 1;
    if (dut_vec() !== want) begin
      failures = failures + 1;
      $display("FAIL %s got=%b want=%b", nm, dut_vec(), want);
    end
  endtask

  task automatic lit(input string nm, input logic [6:0] want, input logic want_h);
    lit_v(nm, want);
    checks = checks + 1;
    if (bus.halted !== want_h) begin
      failures = failures + 1;
      $display("FAIL %s_halted got=%b want=%b", nm, bus.halted, want_h);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    m_left = 0; m_halted = 0; m_stall = '0; m_flush = '0;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    lit_v("rst_vec", V_NORM);
    cyc(); cyc();
    rst = 1'b0;
    lit("reset_state", V_NORM, 1'b0);
    cyc();

    set_in(3, 0, 0, 3, 1, 0, 0, 0, 0);  lit("luh_rs", V_LUH, 1'b0);        cyc();
    set_in(3, 0, 0, 0, 0, 0, 0, 0, 0);  lit("luh_release", V_NORM, 1'b0);  cyc();
    set_in(0, 0, 0, 0, 1, 0, 0, 0, 0);  lit("r0_nohaz", V_NORM, 1'b0);     cyc();
    set_in(1, 5, 1, 5, 1, 0, 0, 0, 1);  lit("mm_frz1", V_FRZ, 1'b0);       cyc();
                                        lit("mm_frz2", V_FRZ, 1'b0);       cyc();
    set_in(1, 5, 1, 5, 1, 0, 0, 0, 0);  lit("luh_rt", V_LUH, 1'b0);        cyc();
    set_in(0, 0, 0, 0, 0, 1, 0, 1, 0);  lit("br_ifmiss", V_BR, 1'b0);      cyc();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);  lit("ifmiss", V_BUB, 1'b0);        cyc();
    set_in(2, 0, 0, 2, 1, 1, 1, 0, 0);  lit("luh_over_br", V_LUH, 1'b0);   cyc();
    set_in(2, 7, 0, 7, 1, 0, 0, 0, 0);  lit("rt_unused", V_NORM, 1'b0);    cyc();
    set_in(0, 0, 0, 0, 0, 1, 1, 0, 1);  lit("mm_over_br", V_FRZ, 1'b0);    cyc();

    // Directed mix of small register indices; model judges each cycle.
    for (int i = 0; i < 30; i++) begin
      set_in(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      cyc();
    end

    // HLT with no misses: three drain cycles, then halted.
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);  lit("hlt", V_BUB, 1'b0);           cyc();
    set_in(0, 0, 0, 0, 0, 1, 0, 1, 0);  lit("drain1", V_BUB, 1'b0);        cyc();
                                        lit("drain2", V_BUB, 1'b0);        cyc();
                                        lit("drain3", V_BUB, 1'b0);        cyc();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);  lit("halted", V_FRZ, 1'b1);        cyc();
    set_in(3, 0, 0, 3, 1, 1, 1, 1, 1);  lit("halt_hold", V_FRZ, 1'b1);     cyc();

    rst = 1'b1;  set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);  lit_v("rst_from_halt", V_NORM);  cyc();
    rst = 1'b0;  lit("run_after_halt", V_NORM, 1'b0);

    // HLT with a mem_miss pulse in DRAIN: halted one cycle later.
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);  cyc();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);  lit("drain_mm", V_DRMM, 1'b0);     cyc();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);  lit("drain_after_mm", V_BUB, 1'b0); cyc();
                                        cyc();
                                        lit("drain_ext", V_BUB, 1'b0);     cyc();
                                        lit("halted_ext", V_FRZ, 1'b1);    cyc();

    rst = 1'b1;  cyc();
    rst = 1'b0;

    // Reset during DRAIN returns to RUN on the next edge.
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);  cyc();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc();
    rst = 1'b1;  lit_v("rst_in_drain", V_NORM);  cyc();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 1, 0, 0, 0);  lit("run_after_rst", V_BR, 1'b0);
`ifdef PIPE_HAZARD_PERF_EN
    checks = checks + 1;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      failures = failures + 1;
      $display("FAIL perf_rst got stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt);
    end
`endif
    cyc();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
